// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared constants and FSM state encoding for the 128x16 single-port SRAM controller.
package ct_f_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 128;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/ct_f_spsram_128x16_ctrl.sv
// Host-side controller for a 128x16 single-port SRAM: clear sweep after reset or
// on request, same-cycle bit-masked writes, and 1-cycle-latency reads with backpressure.
module ct_f_spsram_128x16_ctrl #(
  parameter int ADDR_WIDTH = ct_f_spsram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_f_spsram_ctrl_pkg::DATA_WIDTH,
  parameter int DEPTH      = ct_f_spsram_ctrl_pkg::DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  init_req,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  import ct_f_spsram_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONES   = {DATA_WIDTH{1'b1}};

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] k_r;
  logic                  rd_acc_s;
  logic                  wr_acc_s;

  // The SRAM holds Q while CEN is high, so read data comes straight from the pins.
  assign rsp_rdata = sram_q;

  // Ready/status flags and request acceptance.
  always_comb begin
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    init_done = 1'b0;
    if (RST) begin
      req_rdy   = 1'b0;
      rsp_vld   = 1'b0;
      init_done = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          req_rdy   = 1'b1;
          init_done = 1'b1;
        end
        RSP: begin
          req_rdy   = rsp_rdy;
          rsp_vld   = 1'b1;
          init_done = 1'b1;
        end
        default: begin
          req_rdy   = 1'b0;
          init_done = 1'b0;
        end
      endcase
    end
    rd_acc_s = req_vld & req_rdy & ~req_wr;
    wr_acc_s = req_vld & req_rdy & req_wr;
  end

  // SRAM pin drive: sweep writes in INIT, otherwise follow the accepted request.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = ONES;
    sram_a    = '0;
    sram_d    = '0;
    if (RST) begin
      sram_cen = 1'b1;
    end else if (state_r == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = k_r;
    end else if (wr_acc_s && (req_bmask != '0)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_bmask;
      sram_d    = req_wdata;
      sram_a    = req_addr;
    end else if (rd_acc_s) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
    end else begin
      sram_cen = 1'b1;
    end
  end

  // Controller FSM and sweep counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= INIT;
      k_r     <= '0;
    end else begin
      case (state_r)
        INIT: begin
          if (k_r == K_LAST) begin
            state_r <= IDLE;
            k_r     <= '0;
          end else begin
            k_r <= k_r + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          // A request in the same cycle as init_req is still performed before the sweep.
          if (init_req) begin
            state_r <= INIT;
            k_r     <= '0;
          end else if (rd_acc_s) begin
            state_r <= RSP;
          end else begin
            state_r <= IDLE;
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            state_r <= rd_acc_s ? RSP : IDLE;
          end else begin
            state_r <= RSP;
          end
        end
        default: begin
          state_r <= INIT;
          k_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_128x16_ctrl.sv
// Randomized scoreboard bench for ct_f_spsram_128x16_ctrl with a behavioural SRAM and memory model.
module tb_ct_f_spsram_128x16_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_vld, req_rdy, req_wr;
  logic [6:0]  req_addr;
  logic [15:0] req_wdata, req_bmask;
  logic        rsp_vld, rsp_rdy;
  logic [15:0] rsp_rdata;
  logic        init_req, init_done;
  logic [6:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [15:0] sram_wen, sram_d, sram_q;

  int vectors = 0;
  int errors  = 0;
  int rsp_count = 0;
  bit rand_phase = 0;

  logic [15:0] ref_mem [128];
  logic [15:0] exp_q [$];
  logic [15:0] sram_mem [128];

  always #5 CLK = ~CLK;

  ct_f_spsram_128x16_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_req(init_req), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural SRAM: active-low controls, per-bit write enable, Q held when not read.
  always @(posedge CLK) begin
    if (sram_cen == 1'b0) begin
      if (sram_gwen == 1'b0)
        sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= sram_mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered response must match the oldest expected read value.
  always @(negedge CLK) begin
    if (RST === 1'b0 && rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
      rsp_count++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_data", {16'h0, rsp_rdata}, {16'h0, exp_q.pop_front()});
    end
  end

  // Random backpressure on the response channel.
  always @(posedge CLK) begin
    #1;
    if (rand_phase) rsp_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic clear_model();
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic issue(input logic wr, input logic [6:0] addr, input logic [15:0] wd,
                       input logic [15:0] bm, output int cyc);
    bit got = 0;
    cyc = 0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_bmask = bm;
    while (!got && cyc < 50) begin
      @(negedge CLK);
      if (req_rdy === 1'b1) begin
        got = 1;
        if (wr) begin
          if (bm == 16'h0000) chk("zero_mask_cen", {31'h0, sram_cen}, 32'd1);
          else chk("wr_drive", {sram_cen, sram_gwen, sram_a, sram_wen}, {1'b0, 1'b0, addr, ~bm});
          ref_mem[addr] = (ref_mem[addr] & ~bm) | (wd & bm);
        end else begin
          exp_q.push_back(ref_mem[addr]);
          chk("rd_drive", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b1, addr});
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    req_vld = 1'b0;
    if (!got) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge CLK);
      chk("sweep_a", {25'h0, sram_a}, i);
      chk("sweep_ctl", {28'h0, sram_cen, sram_gwen, init_done, req_rdy}, 32'd0);
      chk("sweep_wen_d", {sram_wen, sram_d}, 32'd0);
      @(posedge CLK); #1;
    end
  endtask

  task automatic chk_ready_after_sweep();
    @(negedge CLK);
    chk("init_done_rdy", {30'h0, init_done, req_rdy}, 32'd3);
    @(posedge CLK); #1;
  endtask

  task automatic chk_reset_outputs();
    @(negedge CLK);
    chk("rst_flags", {27'h0, req_rdy, rsp_vld, init_done, sram_cen, sram_gwen}, 32'h03);
    chk("rst_wen", {16'h0, sram_wen}, 32'h0000_ffff);
    chk("rst_a_d", {9'h0, sram_a, sram_d}, 32'd0);
  endtask

  // Read one address and check the first response cycle directly.
  task automatic read_check(input logic [6:0] addr, input logic [15:0] want, input string name);
    int c;
    issue(1'b0, addr, 16'h0, 16'h0, c);
    @(negedge CLK);
    chk("rd_latency", {31'h0, rsp_vld}, 32'd1);
    chk(name, {16'h0, rsp_rdata}, {16'h0, want});
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    logic [15:0] held;
    RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = 7'h0;
    req_wdata = 16'h0; req_bmask = 16'h0; rsp_rdy = 1'b1; init_req = 1'b0;
    clear_model();

    chk_reset_outputs();
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_sweep(0, 127);
    chk_ready_after_sweep();

    // Full write then read, partial write, zero-mask write.
    issue(1'b1, 7'd5, 16'hA5A5, 16'hFFFF, c);
    read_check(7'd5, 16'hA5A5, "full_rd");
    issue(1'b1, 7'd5, 16'h1234, 16'h00FF, c);
    read_check(7'd5, 16'hA534, "partial_rd");
    issue(1'b1, 7'd5, 16'hFFFF, 16'h0000, c);
    read_check(7'd5, 16'hA534, "zero_mask_rd");

    // Back-to-back reads then held response.
    for (int a = 1; a <= 3; a++) issue(1'b1, 7'(a), 16'($urandom), 16'hFFFF, c);
    base = rsp_count;
    issue(1'b0, 7'd1, 16'h0, 16'h0, c);
    issue(1'b0, 7'd2, 16'h0, 16'h0, c);
    chk("b2b_no_stall2", c, 32'd1);
    issue(1'b0, 7'd3, 16'h0, 16'h0, c);
    chk("b2b_no_stall3", c, 32'd1);
    rsp_rdy = 1'b0;
    held = ref_mem[3];
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("hold_flags", {29'h0, rsp_vld, req_rdy, sram_cen}, 32'h5);
      chk("hold_data", {16'h0, rsp_rdata}, {16'h0, held});
      @(posedge CLK); #1;
    end
    rsp_rdy = 1'b1;
    @(posedge CLK); #1;
    chk("b2b_count", rsp_count - base, 32'd3);

    // Clear sweep on init_req.
    init_req = 1'b1;
    @(posedge CLK); #1;
    init_req = 1'b0;
    clear_model();
    chk_sweep(0, 127);
    chk_ready_after_sweep();
    read_check(7'd5, 16'h0000, "cleared_rd");

    // Reset in the middle of a sweep restarts it from 0.
    issue(1'b1, 7'd9, 16'hBEEF, 16'hFFFF, c);
    init_req = 1'b1;
    @(posedge CLK); #1;
    init_req = 1'b0;
    chk_sweep(0, 59);
    RST = 1'b1;
    chk_reset_outputs();
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_model();
    chk_sweep(0, 127);
    chk_ready_after_sweep();
    read_check(7'd9, 16'h0000, "rst_sweep_rd");

    // Randomized traffic with response backpressure.
    rand_phase = 1;
    for (int n = 0; n < 300; n++) begin
      logic [15:0] bm;
      case ($urandom_range(0, 3))
        0: bm = 16'h0000;
        1: bm = 16'hFFFF;
        default: bm = 16'($urandom);
      endcase
      issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 16'($urandom), bm, c);
    end
    rand_phase = 0;
    @(posedge CLK); #1;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
